// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads a 16-bit instruction as two bytes into the IR.
// It latches the instruction in DECODE and holds it in DISPATCH until execute
// acknowledges it. Opcode HALT_OP parks the unit in HALT until reset.
// Control outputs follow the state. The one exception is FETCH_L, where Enable
// gates the memory access so that no read or PC increment happens while
// fetching is not permitted.
module instruction_fetch_unit #(
  parameter logic [2:0] ARF_PC_REGSEL   = 3'b011,
  parameter logic [2:0] ARF_NONE_REGSEL = 3'b111,
  parameter logic [1:0] ARF_INC         = 2'b01,
  parameter logic [1:0] ARF_PC_OUT      = 2'b00,
  parameter logic [5:0] HALT_OP         = 6'h3F
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [15:0] IROut,
  input  logic        Exec_Done,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic        IR_Write,
  output logic        IR_LH,
  output logic [2:0]  ARF_RegSel,
  output logic [1:0]  ARF_FunSel,
  output logic [1:0]  ARF_OutDSel,
  output logic        Instr_Valid,
  output logic [5:0]  Opcode,
  output logic [9:0]  Operand,
  output logic [15:0] Instr_Count,
  output logic        Halted,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_FETCH_L  = 3'd0,
    S_FETCH_H  = 3'd1,
    S_DECODE   = 3'd2,
    S_DISPATCH = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        fetch_active;

  // State, latched instruction and dispatch counter registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_FETCH_L;
      instr_q       <= 16'h0000;
      instr_count_q <= 16'h0000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state, instruction latch and dispatch count
  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves it
    // unassigned, which would infer a latch.
    state_d       = state_q;
    instr_d       = instr_q;
    instr_count_d = instr_count_q;
    case (state_q)
      S_FETCH_L: begin
        if (Enable) state_d = S_FETCH_H;
      end
      S_FETCH_H: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        instr_d = IROut;
        state_d = (IROut[15:10] == HALT_OP) ? S_HALT : S_DISPATCH;
      end
      S_DISPATCH: begin
        if (Exec_Done) begin
          instr_count_d = instr_count_q + 16'd1;
          state_d       = S_FETCH_L;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH_L;
      end
    endcase
  end

  // Memory, IR and ARF controls: a PC read with increment while fetching, idle otherwise
  always_comb begin
    fetch_active = ((state_q == S_FETCH_L) && Enable) || (state_q == S_FETCH_H);
    Mem_CS       = 1'b1;
    Mem_WR       = 1'b0;
    IR_Write     = 1'b0;
    IR_LH        = 1'b0;
    ARF_RegSel   = ARF_NONE_REGSEL;
    ARF_FunSel   = 2'b00;
    ARF_OutDSel  = ARF_PC_OUT;
    if (fetch_active) begin
      Mem_CS     = 1'b0;
      IR_Write   = 1'b1;
      IR_LH      = (state_q == S_FETCH_H);
      ARF_RegSel = ARF_PC_REGSEL;
      ARF_FunSel = ARF_INC;
    end
  end

  assign Instr_Valid = (state_q == S_DISPATCH);
  assign Halted      = (state_q == S_HALT);
  assign State       = state_q;
  assign Opcode      = instr_q[15:10];
  assign Operand     = instr_q[9:0];
  assign Instr_Count = instr_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit. It models a byte memory, the PC and the IR
// around the DUT. A phase-level reference model predicts every output, and the
// bench compares on each falling edge. Directed steps pin literal values.
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [15:0] IROut;
  logic        Exec_Done;
  logic        Mem_CS, Mem_WR, IR_Write, IR_LH;
  logic [2:0]  ARF_RegSel;
  logic [1:0]  ARF_FunSel, ARF_OutDSel;
  logic        Instr_Valid, Halted;
  logic [5:0]  Opcode;
  logic [9:0]  Operand;
  logic [15:0] Instr_Count;
  logic [2:0]  State;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_unit dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Enable      (Enable),
    .IROut       (IROut),
    .Exec_Done   (Exec_Done),
    .Mem_CS      (Mem_CS),
    .Mem_WR      (Mem_WR),
    .IR_Write    (IR_Write),
    .IR_LH       (IR_LH),
    .ARF_RegSel  (ARF_RegSel),
    .ARF_FunSel  (ARF_FunSel),
    .ARF_OutDSel (ARF_OutDSel),
    .Instr_Valid (Instr_Valid),
    .Opcode      (Opcode),
    .Operand     (Operand),
    .Instr_Count (Instr_Count),
    .Halted      (Halted),
    .State       (State)
  );

  always #5 Clock = ~Clock;

  // Environment: byte memory, PC and IR respond to the DUT's controls
  logic [7:0]  mem [256];
  logic [15:0] pc   = 16'h0000;
  logic [15:0] ir_q = 16'h0000;
  assign IROut = ir_q;

  always @(posedge Clock) begin
    if (!Mem_CS && !Mem_WR && IR_Write) begin
      if (IR_LH) ir_q[15:8] <= mem[pc[7:0]];
      else       ir_q[7:0]  <= mem[pc[7:0]];
    end
    if (ARF_RegSel == 3'b011 && ARF_FunSel == 2'b01) pc <= pc + 16'd1;
  end

  // Reference model: phase 0..4 = FETCH_L, FETCH_H, DECODE, DISPATCH, HALT
  logic [2:0]  m_phase;
  logic [15:0] m_instr;
  logic [15:0] m_disp;
  logic [15:0] count_base;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_phase <= 3'd0;
      m_instr <= 16'h0000;
      m_disp  <= 16'h0000;
    end else begin
      case (m_phase)
        3'd0: if (Enable) m_phase <= 3'd1;
        3'd1: m_phase <= 3'd2;
        3'd2: begin
          m_instr <= ir_q;
          m_phase <= (ir_q[15:10] == 6'h3F) ? 3'd4 : 3'd3;
        end
        3'd3: if (Exec_Done) begin
          m_disp  <= m_disp + 16'd1;
          m_phase <= 3'd0;
        end
        default: m_phase <= m_phase;
      endcase
    end
  end

  // {Mem_CS, Mem_WR, IR_Write, IR_LH, RegSel, FunSel, OutDSel}
  function automatic logic [11:0] exp_ctrl(input logic [2:0] ph, input logic en);
    if ((ph == 3'd0 && en) || ph == 3'd1)
      return {1'b0, 1'b0, 1'b1, (ph == 3'd1), 3'b011, 2'b01, 2'b00};
    return {1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 2'b00, 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge Clock) begin
    check("m_state", {29'd0, State}, {29'd0, m_phase});
    check("m_ctrl", {20'd0, Mem_CS, Mem_WR, IR_Write, IR_LH, ARF_RegSel, ARF_FunSel, ARF_OutDSel},
          {20'd0, exp_ctrl(m_phase, Enable)});
    check("m_valid", {31'd0, Instr_Valid}, {31'd0, (m_phase == 3'd3)});
    check("m_halted", {31'd0, Halted}, {31'd0, (m_phase == 3'd4)});
    check("m_instr", {16'd0, Opcode, Operand}, {16'd0, m_instr});
    check("m_count", {16'd0, Instr_Count}, {16'd0, count_base + m_disp});
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_instr(input logic [15:0] w);
    mem[pc[7:0]]         = w[7:0];
    mem[pc[7:0] + 8'd1]  = w[15:8];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    count_base = 16'h0000;
    Reset      = 1'b1;
    Enable     = 1'b0;
    Exec_Done  = 1'b0;
    #1;
    check("rst_state", {29'd0, State}, 32'd0);
    check("rst_count", {16'd0, Instr_Count}, 32'd0);
    check("rst_valid", {31'd0, Instr_Valid}, 32'd0);
    check("rst_halted", {31'd0, Halted}, 32'd0);
    tick();
    tick();
    Reset = 1'b0;

    // Enable low: stay idle in FETCH_L
    for (int i = 0; i < 5; i++) begin
      check("idle_state", {29'd0, State}, 32'd0);
      check("idle_cs", {31'd0, Mem_CS}, 32'd1);
      check("idle_irw", {31'd0, IR_Write}, 32'd0);
      tick();
    end

    // First fetch of 0x1234 from bytes 0x34, 0x12
    load_instr(16'h1234);
    Exec_Done = 1'b1;
    Enable    = 1'b1;
    #1;
    check("fetch_start_cs", {31'd0, Mem_CS}, 32'd0);
    tick();
    tick();
    tick();
    check("lat3_valid", {31'd0, Instr_Valid}, 32'd1);
    check("lat3_opcode", {26'd0, Opcode}, 32'h04);
    check("lat3_operand", {22'd0, Operand}, 32'h234);
    Enable = 1'b0;
    tick();
    check("count_one", {16'd0, Instr_Count}, 32'd1);

    // Long dispatch: Exec_Done low for 10 cycles
    load_instr(16'h2805);
    Exec_Done = 1'b0;
    Enable    = 1'b1;
    tick();
    tick();
    tick();
    Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", {31'd0, Instr_Valid}, 32'd1);
      check("hold_opcode", {26'd0, Opcode}, 32'h0A);
      if (i < 9) tick();
    end
    Exec_Done = 1'b1;
    tick();
    check("hold_back_state", {29'd0, State}, 32'd0);
    check("hold_count", {16'd0, Instr_Count}, 32'd2);

    // Reset during FETCH_H
    load_instr(16'h4321);
    Enable = 1'b1;
    tick();
    check("mid_state_fh", {29'd0, State}, 32'd1);
    Reset      = 1'b1;
    count_base = 16'h0000;
    #1;
    check("mid_rst_state", {29'd0, State}, 32'd0);
    check("mid_rst_count", {16'd0, Instr_Count}, 32'd0);
    check("mid_rst_opcode", {26'd0, Opcode}, 32'd0);
    check("mid_rst_valid", {31'd0, Instr_Valid}, 32'd0);
    tick();
    Reset = 1'b0;
    check("refetch_state", {29'd0, State}, 32'd0);
    check("refetch_lh", {31'd0, IR_LH}, 32'd0);
    check("refetch_cs", {31'd0, Mem_CS}, 32'd0);
    tick();
    check("refetch_fh_lh", {31'd0, IR_LH}, 32'd1);
    tick();
    tick();
    Enable = 1'b0;
    tick();
    check("refetch_count", {16'd0, Instr_Count}, 32'd1);

    // Counter wrap: preload 0xFFFF, then one dispatch
    force dut.instr_count_q = 16'hFFFF;
    count_base = 16'hFFFF - m_disp;
    tick();
    release dut.instr_count_q;
    check("wrap_preload", {16'd0, Instr_Count}, 32'hFFFF);
    load_instr(16'h0800);
    Enable = 1'b1;
    tick();
    tick();
    tick();
    Enable = 1'b0;
    check("wrap_opcode", {26'd0, Opcode}, 32'h02);
    tick();
    check("wrap_count", {16'd0, Instr_Count}, 32'h0000);

    // Halt instruction 0xFC00
    load_instr(16'hFC00);
    Enable = 1'b1;
    tick();
    tick();
    tick();
    check("halt_state", {29'd0, State}, 32'd4);
    check("halt_halted", {31'd0, Halted}, 32'd1);
    check("halt_valid", {31'd0, Instr_Valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("halt_cs", {31'd0, Mem_CS}, 32'd1);
      check("halt_count", {16'd0, Instr_Count}, 32'h0000);
      tick();
    end
    Reset      = 1'b1;
    count_base = 16'h0000;
    #1;
    check("halt_rst_state", {29'd0, State}, 32'd0);
    check("halt_rst_halted", {31'd0, Halted}, 32'd0);
    tick();
    Reset  = 1'b0;
    Enable = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
